// File: rtl/addsub_pkg.sv
// addsub_pkg: shared mode type and parameter sanity check for the pipelined adder/subtractor
package addsub_pkg;
    typedef enum logic {ADD = 1'b0, SUB = 1'b1} addsub_mode_t;
    function automatic bit split_ok(int width, int stages);
        return width >= 1 && stages >= 1 && stages <= width && width % stages == 0;
    endfunction
endpackage

// File: rtl/addsub_pipe_if.sv
// addsub_pipe_if: operand/result streams of addsub_pipe with valid/ready handshakes
interface addsub_pipe_if
    import addsub_pkg::*;
#(parameter int WIDTH = 16);
    logic in_valid, in_ready, ci, out_valid, out_ready, co, ovf;
    logic [WIDTH-1:0] a, b, s;
    addsub_mode_t mode;
    modport master(output in_valid, a, b, ci, mode, out_ready, input in_ready, out_valid, s, co, ovf);
    modport slave(input in_valid, a, b, ci, mode, out_ready, output in_ready, out_valid, s, co, ovf);
endinterface

// File: rtl/addsub_slice.sv
// addsub_slice: combinational CW-bit ripple adder exposing carry-out and the carry into its MSB
module addsub_slice #(parameter int CW = 4) (
    input  logic [CW-1:0] a,
    input  logic [CW-1:0] b,
    input  logic          ci,
    output logic [CW-1:0] s,
    output logic          co,
    output logic          cm
);
    logic [CW:0] c;
    always_comb begin
        c = '0;
        s = '0;
        c[0] = ci;
        for (int i = 0; i < CW; i++) begin
            s[i] = a[i] ^ b[i] ^ c[i];
            c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    end
    assign co = c[CW];
    assign cm = c[CW-1];
endmodule

// File: rtl/addsub_pipe.sv
// addsub_pipe: STAGES-deep chunked add/subtract pipeline, one chunk per stage, whole-pipe stall
module addsub_pipe
    import addsub_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input logic clk,
    input logic rst,
    addsub_pipe_if.slave bus
);
    localparam int CW = WIDTH / STAGES;
    if (!split_ok(WIDTH, STAGES)) begin : g_bad
        $error("addsub_pipe: STAGES must evenly divide WIDTH");
    end
    logic advance;
    assign advance = !bus.out_valid || bus.out_ready;
    assign bus.in_ready = advance;
    for (genvar k = 0; k < STAGES; k++) begin : st
        logic [WIDTH-k*CW-1:0] xa, xb;
        logic [WIDTH-1:0] xs, rs;
        logic [CW-1:0] sum;
        logic xc, xv, xo, co, cm, rc, rv, ro;
        if (k == 0) begin : g_in
            assign xa = bus.a;
            assign xb = bus.mode == SUB ? ~bus.b : bus.b;
            assign xc = bus.mode == SUB ? ~bus.ci : bus.ci;
            assign xv = bus.in_valid;
            assign xs = '0;
            assign xo = 1'b0;
        end else begin : g_in
            assign xa = st[k-1].g_op.ra;
            assign xb = st[k-1].g_op.rb;
            assign xc = st[k-1].rc;
            assign xv = st[k-1].rv;
            assign xs = st[k-1].rs;
            assign xo = st[k-1].ro;
        end
        addsub_slice #(.CW(CW)) u_slice (
            .a(xa[CW-1:0]), .b(xb[CW-1:0]), .ci(xc), .s(sum), .co(co), .cm(cm)
        );
        always_ff @(posedge clk or posedge rst)
            if (rst) rv <= 1'b0;
            else if (advance) rv <= xv;
        // sum chunks enter at the top and shift down, so the last stage holds the aligned result
        always_ff @(posedge clk)
            if (advance) begin
                rs <= (xs >> CW) | (WIDTH'(sum) << (WIDTH - CW));
                rc <= co;
                ro <= k == STAGES - 1 ? cm ^ co : xo;
            end
        if (k < STAGES - 1) begin : g_op
            logic [WIDTH-(k+1)*CW-1:0] ra, rb;
            always_ff @(posedge clk)
                if (advance) begin
                    ra <= xa[WIDTH-k*CW-1:CW];
                    rb <= xb[WIDTH-k*CW-1:CW];
                end
        end
    end
    assign bus.out_valid = st[STAGES-1].rv;
    assign bus.s = bus.out_valid ? st[STAGES-1].rs : '0;
    assign bus.co = bus.out_valid && st[STAGES-1].rc;
    assign bus.ovf = bus.out_valid && st[STAGES-1].ro;
endmodule

// File: tb/tb_addsub_pipe.sv
// tb_addsub_pipe: directed checks of addsub_pipe in 8/2, 16/4 and 4/1 configurations
module tb_addsub_pipe;
  import addsub_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  addsub_pipe_if #(.WIDTH(8)) i8 ();
  addsub_pipe_if #(.WIDTH(16)) i16 ();
  addsub_pipe_if #(.WIDTH(4)) i4 ();
  addsub_pipe #(.WIDTH(8), .STAGES(2)) u8 (.clk(clk), .rst(rst), .bus(i8));
  addsub_pipe #(.WIDTH(16), .STAGES(4)) u16 (.clk(clk), .rst(rst), .bus(i16));
  addsub_pipe #(.WIDTH(4), .STAGES(1)) u4 (.clk(clk), .rst(rst), .bus(i4));
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic logic [17:0] model(int w, logic [15:0] a, logic [15:0] b, logic ci, logic sub);
    int ua, ub, sa, sb, c, r, sr;
    logic co, ov;
    ua = int'(a);
    ub = int'(b);
    c = ci ? 1 : 0;
    sa = a[w-1] ? ua - (1 << w) : ua;
    sb = b[w-1] ? ub - (1 << w) : ub;
    r = sub ? ua - ub - c : ua + ub + c;
    sr = sub ? sa - sb - c : sa + sb + c;
    co = sub ? (r >= 0) : (r >= (1 << w));
    ov = sr < -(1 << (w - 1)) || sr >= (1 << (w - 1));
    return {ov, co, 16'(r & ((1 << w) - 1))};
  endfunction
  task automatic beat8(input logic [7:0] a, input logic [7:0] b, input logic ci, input addsub_mode_t m,
                       input logic [9:0] exp, input string tag);
    i8.a = a; i8.b = b; i8.ci = ci; i8.mode = m; i8.in_valid = 1'b1;
    @(posedge clk); #1;
    i8.in_valid = 1'b0;
    chk({tag, "_lat"}, i8.out_valid, 1'b0);
    @(posedge clk); #1;
    chk(tag, {i8.out_valid, i8.ovf, i8.co, i8.s}, {1'b1, exp});
  endtask
  initial begin
    logic [17:0] q[$];
    logic [17:0] m;
    logic [10:0] held;
    logic hold;
    int sent, got, cyc;
    i8.in_valid = 0; i8.out_ready = 1; i8.a = 0; i8.b = 0; i8.ci = 0; i8.mode = ADD;
    i16.in_valid = 0; i16.out_ready = 1; i16.a = 0; i16.b = 0; i16.ci = 0; i16.mode = ADD;
    i4.in_valid = 0; i4.out_ready = 1; i4.a = 0; i4.b = 0; i4.ci = 0; i4.mode = ADD;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out8", {i8.out_valid, i8.s, i8.co, i8.ovf, i8.in_ready}, 12'h001);
    chk("reset_out16", {i16.out_valid, i16.s, i16.co, i16.ovf, i16.in_ready}, 20'h00001);
    rst = 1'b0;
    beat8(8'h7F, 8'h01, 1'b0, ADD, {1'b1, 1'b0, 8'h80}, "add_7f_01");
    beat8(8'h00, 8'h01, 1'b0, SUB, {1'b0, 1'b0, 8'hFF}, "sub_00_01");
    beat8(8'h80, 8'h01, 1'b0, SUB, {1'b1, 1'b1, 8'h7F}, "sub_80_01");
    beat8(8'h10, 8'h05, 1'b1, SUB, {1'b0, 1'b1, 8'h0A}, "sub_borrow_in");
    i16.a = 16'hFFFF; i16.b = 16'h0000; i16.ci = 1'b1; i16.mode = ADD; i16.in_valid = 1'b1;
    @(posedge clk); #1;
    i16.in_valid = 1'b0;
    for (int i = 1; i < 4; i++) begin
      chk("ripple_lat", i16.out_valid, 1'b0);
      @(posedge clk); #1;
    end
    chk("ripple_all_stages", {i16.out_valid, i16.ovf, i16.co, i16.s}, {3'b101, 16'h0000});
    sent = 0; got = 0; cyc = 0; hold = 1'b0; held = '0;
    while (got < 20 && cyc < 400) begin
      @(posedge clk); #1;
      if (hold) chk("stall_stable", {i8.out_valid, i8.ovf, i8.co, i8.s}, held);
      i8.out_ready = 1'($urandom_range(0, 1));
      i8.in_valid = sent < 20;
      i8.a = 8'($urandom); i8.b = 8'($urandom); i8.ci = 1'($urandom_range(0, 1));
      i8.mode = addsub_mode_t'($urandom_range(0, 1));
      #1;
      if (i8.in_valid && i8.in_ready) begin
        q.push_back(model(8, {8'h00, i8.a}, {8'h00, i8.b}, i8.ci, i8.mode == SUB));
        sent++;
      end
      if (i8.out_valid && i8.out_ready) begin
        chk("stream_nonempty", q.size() != 0, 1'b1);
        if (q.size() != 0) begin
          m = q.pop_front();
          chk("stream_result", {i8.ovf, i8.co, i8.s}, {m[17:16], m[7:0]});
        end
        got++;
      end
      if (i8.out_valid && !i8.out_ready) i8.in_valid = 1'b0;
      hold = i8.out_valid && !i8.out_ready;
      held = {i8.out_valid, i8.ovf, i8.co, i8.s};
      cyc++;
    end
    @(posedge clk); #1;
    i8.in_valid = 1'b0; i8.out_ready = 1'b1;
    chk("stream_count", got, 20);
    repeat (3) @(posedge clk);
    #1;
    chk("stream_no_dup", i8.out_valid, 1'b0);
    i16.out_ready = 1'b0; i16.mode = SUB; i16.ci = 1'b0; i16.in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      i16.a = 16'h1234 + 16'(i); i16.b = 16'h0101;
      @(posedge clk); #1;
    end
    i16.in_valid = 1'b0;
    chk("full_out_valid", i16.out_valid, 1'b1);
    chk("full_in_ready", i16.in_ready, 1'b0);
    chk("full_head", i16.s, 16'h1133);
    rst = 1'b1;
    #1;
    chk("async_reset", {i16.out_valid, i16.s, i16.co, i16.ovf}, 19'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    i16.out_ready = 1'b1;
    chk("post_reset_in_ready", i16.in_ready, 1'b1);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk("no_stale", i16.out_valid, 1'b0);
    end
    for (int md = 0; md < 2; md++)
      for (int c = 0; c < 2; c++)
        for (int a = 0; a < 16; a++)
          for (int b = 0; b < 16; b++) begin
            i4.a = 4'(a); i4.b = 4'(b); i4.ci = 1'(c); i4.mode = addsub_mode_t'(md);
            i4.in_valid = 1'b1;
            m = model(4, 16'(a), 16'(b), 1'(c), md == 1);
            @(posedge clk); #1;
            chk("sweep4", {i4.out_valid, i4.ovf, i4.co, i4.s}, {1'b1, m[17:16], m[3:0]});
          end
    i4.in_valid = 1'b0;
    @(posedge clk); #1;
    chk("sweep4_drain", i4.out_valid, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
